// File: rtl/sign_narrow_stream_pkg.sv
// sign_narrow_pkg: output range helpers, saturation values and parameter legality check for sign_narrow_stream
package sign_narrow_pkg;

    // Largest representable OUT_W-bit signed value (positive saturation)
    function automatic int out_max(int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // Smallest representable OUT_W-bit signed value (negative saturation)
    function automatic int out_min(int out_w);
        return -(1 << (out_w - 1));
    endfunction

    // Saturation patterns: 0 followed by ones, 1 followed by zeros
    function automatic int sat_pos(int out_w);
        return out_max(out_w);
    endfunction

    function automatic int sat_neg(int out_w);
        return out_min(out_w);
    endfunction

    // Narrowing only makes sense to a strictly smaller width of at least 2 bits
    function automatic bit params_ok(int in_w, int out_w);
        return (in_w > out_w) && (out_w >= 2);
    endfunction

endpackage

// File: rtl/sign_narrow_stream_if.sv
// sign_narrow_stream_if: wide input stream and narrow output stream handshake bundle
interface sign_narrow_stream_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/sign_narrow_stream_range.sv
// sign_narrow_range: combinational range check and narrowing; saturates when SIGN_NARROW_SATURATE_EN is defined, wraps otherwise
module sign_narrow_range
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] data_o,
    output logic             ovf_o
);
    // The value fits when every bit from the MSB down to the narrow sign bit agrees
    logic [IN_W-OUT_W:0] top_bits;

    assign top_bits = data_i[IN_W-1:OUT_W-1];
    assign ovf_o    = !((&top_bits) || !(|top_bits));

`ifdef SIGN_NARROW_SATURATE_EN
    localparam logic [OUT_W-1:0] SAT_POS = OUT_W'(sat_pos(OUT_W));
    localparam logic [OUT_W-1:0] SAT_NEG = OUT_W'(sat_neg(OUT_W));

    assign data_o = !ovf_o ? data_i[OUT_W-1:0] : data_i[IN_W-1] ? SAT_NEG : SAT_POS;
`else
    assign data_o = data_i[OUT_W-1:0];
`endif
endmodule

// File: rtl/sign_narrow_stream.sv
// sign_narrow_stream: two-stage pipeline narrowing signed words with overflow counter; option macro SIGN_NARROW_SATURATE_EN
module sign_narrow_stream
    import sign_narrow_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sign_narrow_stream_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     ovf_count,
    output logic                 ovf_sticky
);
    if (!params_ok(IN_W, OUT_W)) begin : g_bad_params
        $error("sign_narrow_stream: requires IN_W > OUT_W and OUT_W >= 2");
    end

    logic             s1_valid_q;
    logic [IN_W-1:0]  s1_data_q;
    logic             out_valid_q;
    logic             out_ovf_q;
    logic [OUT_W-1:0] out_data_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             s1_en, s2_en, ovf_fire;
    logic [OUT_W-1:0] nar_data;
    logic             nar_ovf;

    assign s2_en        = !out_valid_q || bus.out_ready;
    assign s1_en        = !s1_valid_q || s2_en;
    assign bus.in_ready = s1_en;
    assign ovf_fire     = out_valid_q && bus.out_ready && out_ovf_q;

    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_valid = out_valid_q;
    assign ovf_count     = cnt_q;
    assign ovf_sticky    = sticky_q;

    sign_narrow_range #(.IN_W(IN_W), .OUT_W(OUT_W)) u_range (
        .data_i (s1_data_q),
        .data_o (nar_data),
        .ovf_o  (nar_ovf)
    );

    // Counter next state: clear wins over an increment, increment stops at all ones
    always_comb begin
        cnt_d    = cnt_clr ? '0 : (ovf_fire && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        sticky_d = cnt_clr ? 1'b0 : sticky_q || ovf_fire;
    end

    // Stage 1 captures the wide word; stage 2 holds the narrowed result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) s1_data_q <= bus.in_data;
            end
            if (s2_en) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= nar_data;
                    out_ovf_q  <= nar_ovf;
                end
            end
        end
    end

    // Overflow event counter and sticky flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end
endmodule

// File: doc/sign_narrow_stream.md
Name: sign_narrow_stream

Overview:
- Streaming inverse of the 2-to-8-bit sign-extension path: accepts wide signed two's-complement words and narrows them to OUT_W-bit signed values.
- Detects words that do not fit OUT_W bits, and either saturates or wraps them (compile option).
- Two-stage registered pipeline with valid/ready handshake on both sides, plus a saturating overflow-event counter.
- Sits between the wide datapath and the narrow-field encoders.

Parameters:
- IN_W, 8, input word width (signed); must satisfy IN_W > OUT_W.
- OUT_W, 2, output word width (signed); must be >= 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  IN_W  wide signed word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  OUT_W  narrowed signed word.
- out_ovf  output  1  out_data came from an out-of-range input (qualified by out_valid).
- out_valid  output  1  out_data/out_ovf valid.
- out_ready  input  1  downstream accepts this cycle.
- ovf_count  output  CNT_W  number of overflowed beats delivered; saturating.
- ovf_sticky  output  1  set by the first delivered overflow beat; held until cleared.
- cnt_clr  input  1  synchronous clear of ovf_count and ovf_sticky.

Behaviour:
- Reset (rst_n low, asynchronous): all valid flags, out_data, out_ovf, ovf_count and ovf_sticky go to 0. In-flight beats are discarded. Reset asserted mid-transfer drops both stages with no partial output.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage enables:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en. This is a combinational path from out_ready and is required.
- S1 registers in_data and computes ovf:
  - ovf = 1 when bits [IN_W-1:OUT_W-1] are not all equal.
  - Representable range is -2^(OUT_W-1) .. 2^(OUT_W-1)-1 (-2..1 at defaults).
- S2 loads the narrowed result from S1 when s2_en. out_valid follows s1_valid on each s2_en.
- Timing:
  - Latency is 2 cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 word per cycle.
  - Order is always preserved; there is no drop and no duplication under any out_ready pattern.
- Backpressure: with out_ready held low, at most 2 words are held (one in S1, one in S2), then in_ready drops. out_data, out_ovf and out_valid stay stable while out_valid && !out_ready.
- Counter:
  - ovf_count increments by 1 on each output transfer with out_ovf=1, and holds at 2^CNT_W-1.
  - ovf_sticky is set on the same event.
  - cnt_clr has priority: if cnt_clr coincides with an increment, the result is 0 and sticky is 0.
- In-range inputs: out_data = in_data[OUT_W-1:0], out_ovf = 0, identical in both compile modes.

Optional Feature:
- Macro: SIGN_NARROW_SATURATE_EN.
- Defined: out-of-range inputs saturate.
  - Positive overflow (sign bit 0) -> 0 followed by all 1s (01 at defaults).
  - Negative overflow -> 1 followed by all 0s (10 at defaults).
- Undefined: out-of-range inputs wrap, i.e. out_data = in_data[OUT_W-1:0].
- out_ovf, ovf_count and ovf_sticky behave identically in both modes.

Decomposition:
- Package sign_narrow_pkg holds:
  - localparam functions for the min and max out values given OUT_W;
  - the saturation constants;
  - the parameter legality check (IN_W > OUT_W, OUT_W >= 2), which fires at elaboration.
- One natural sub-module, sign_narrow_range: purely combinational, IN_W in, OUT_W out plus ovf, instantiated in S1. It contains both the saturate and wrap paths selected by the macro.
- Pipeline registers, handshake and counter live in the top module.

Test Plan (defaults unless stated):
- Basic timing: in 0x01, 0xFF, 0xFE with out_ready=1 -> out 01, 11, 10 with out_ovf=0, first out_valid exactly 2 cycles after accept, back-to-back output.
- Out-of-range: in 0x06 -> out_ovf=1, out 01 (saturate) / 10 (wrap). In 0x80 -> out_ovf=1, out 10 (saturate) / 00 (wrap). After both beats, ovf_count=2 and ovf_sticky=1.
- Backpressure: hold out_ready=0 while offering 0x00, 0x01, 0xFF, 0xFE continuously.
  - Exactly 2 words are accepted, then in_ready=0.
  - Outputs stay stable while stalled.
  - On release, words arrive in order with no loss.
- Random stall: 1000 random words, random in_valid/out_ready -> output stream equals the reference narrowing of the input stream, and ovf_count equals the number of overflows (CNT_W=16).
- Counter edges: with CNT_W=2, 5 overflow beats -> ovf_count=3 (held). cnt_clr asserted in the same cycle as an overflow transfer -> ovf_count=0, ovf_sticky=0.
- Reset mid-flight: rst_n low with both stages full -> out_valid=0 immediately (asynchronous), counter=0. After release, the first new word appears 2 cycles after accept.
